// File: rtl/fetch_queue.sv
// Instruction fetch stage: owns the PC, reads the icache and buffers two {instr, npc} entries for decode.
// Optional FETCH_PERF_CNT_EN adds saturating push and bubble counters as extra output ports.
module fetch_queue #(
    parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RST,
    output logic        imemREN,
    output logic [31:0] imemaddr,
    input  logic [31:0] imemload,
    input  logic        ihit,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic [31:0] instr,
    output logic [31:0] npc,
    output logic        valid
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] fetch_count,
    output logic [31:0] bubble_count
`endif
);

    logic [31:0] r_pc;
    logic [1:0]  r_count;
    logic        r_head;
    logic        r_halted;
    logic [31:0] r_q_instr [2];
    logic [31:0] r_q_npc   [2];

    logic        w_ren;
    logic        w_push;
    logic        w_pop;
    logic        w_valid;
    logic        w_halt_take;
    logic        w_wr_idx;
    logic [31:0] w_pc_next;
    logic [31:0] w_redir_pc;

    assign w_valid     = (r_count != 2'd0);
    assign w_ren       = !r_halted && (r_count != 2'd2) && !redirect;
    assign w_push      = w_ren && ihit;
    assign w_pop       = w_valid && !stall;
    assign w_halt_take = halt && w_valid && !stall && !redirect;
    assign w_wr_idx    = r_head ^ r_count[0];
    assign w_pc_next   = r_pc + 32'd4;
    assign w_redir_pc  = redirect_pc & 32'hFFFF_FFFC;

    assign imemREN  = w_ren;
    assign imemaddr = r_pc & 32'hFFFF_FFFC;
    assign valid    = w_valid;
    assign instr    = w_valid ? r_q_instr[r_head] : 32'h0000_0000;
    assign npc      = w_valid ? r_q_npc[r_head]   : 32'h0000_0000;

    // Control state: redirect beats halt, halt beats normal push/pop bookkeeping.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_pc     <= PC_INIT;
            r_count  <= 2'd0;
            r_head   <= 1'b0;
            r_halted <= 1'b0;
        end else if (redirect) begin
            r_pc     <= w_redir_pc;
            r_count  <= 2'd0;
            r_head   <= 1'b0;
            r_halted <= 1'b0;
        end else if (w_halt_take) begin
            // The fetch still completes, but everything younger than HALT is thrown away.
            if (w_push) begin
                r_pc <= w_pc_next;
            end else begin
                r_pc <= r_pc;
            end
            r_count  <= 2'd0;
            r_head   <= 1'b0;
            r_halted <= 1'b1;
        end else begin
            if (w_push) begin
                r_pc <= w_pc_next;
            end else begin
                r_pc <= r_pc;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
            r_head   <= r_head ^ w_pop;
            r_halted <= r_halted;
        end
    end

    // Queue storage: written only on an accepted push outside redirect/halt cycles.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_q_instr[0] <= 32'h0000_0000;
            r_q_instr[1] <= 32'h0000_0000;
            r_q_npc[0]   <= 32'h0000_0000;
            r_q_npc[1]   <= 32'h0000_0000;
        end else if (w_push && !w_halt_take) begin
            r_q_instr[w_wr_idx] <= imemload;
            r_q_npc[w_wr_idx]   <= w_pc_next;
        end else begin
            r_q_instr[0] <= r_q_instr[0];
            r_q_instr[1] <= r_q_instr[1];
            r_q_npc[0]   <= r_q_npc[0];
            r_q_npc[1]   <= r_q_npc[1];
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_fetch_count;
    logic [31:0] r_bubble_count;

    assign fetch_count  = r_fetch_count;
    assign bubble_count = r_bubble_count;

    // Saturating performance counters, cleared only by RST.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_fetch_count  <= 32'h0000_0000;
            r_bubble_count <= 32'h0000_0000;
        end else begin
            if (w_push && (r_fetch_count != 32'hFFFF_FFFF)) begin
                r_fetch_count <= r_fetch_count + 32'd1;
            end else begin
                r_fetch_count <= r_fetch_count;
            end
            if (!w_valid && !r_halted && (r_bubble_count != 32'hFFFF_FFFF)) begin
                r_bubble_count <= r_bubble_count + 32'd1;
            end else begin
                r_bubble_count <= r_bubble_count;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: stimulus pushes expected {instr, npc}, a negedge monitor pops on each decode.
module tb_fetch_queue;

    logic        CLK = 1'b0;
    logic        RST;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic [31:0] imemload;
    logic        ihit;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        halt;
    logic [31:0] instr;
    logic [31:0] npc;
    logic        valid;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count;
    logic [31:0] bubble_count;
`endif

    int n_checks = 0;
    int n_errors = 0;
    logic [63:0] exp_q [$];

    fetch_queue #(.PC_INIT(32'h0000_0200)) dut (
        .CLK(CLK), .RST(RST),
        .imemREN(imemREN), .imemaddr(imemaddr), .imemload(imemload), .ihit(ihit),
        .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt),
        .instr(instr), .npc(npc), .valid(valid)
`ifdef FETCH_PERF_CNT_EN
        , .fetch_count(fetch_count), .bubble_count(bubble_count)
`endif
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] dw(input logic [31:0] a);
        return a ^ 32'h8C00_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: every decode pop is compared against the oldest expected entry.
    always @(negedge CLK) begin
        if (!RST) begin
            if (valid && !stall && !redirect) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL pop_unexpected: got instr=%h npc=%h expected nothing", instr, npc);
                end else if ({instr, npc} !== exp_q[0]) begin
                    n_errors++;
                    $display("FAIL pop_data: got instr=%h npc=%h expected instr=%h npc=%h",
                             instr, npc, exp_q[0][63:32], exp_q[0][31:0]);
                    void'(exp_q.pop_front());
                end else begin
                    void'(exp_q.pop_front());
                end
                if (halt) exp_q.delete();
            end else if (!valid) begin
                chk("nop_instr", instr, 32'h0);
                chk("nop_npc", npc, 32'h0);
            end
        end
    end

    task automatic step(input logic ih, input logic st, input logic rd, input logic [31:0] rpc,
                        input logic hl, input logic ren_e, input logic [31:0] addr_e,
                        input logic push_e, input int valid_e);
        logic [31:0] n;
        @(posedge CLK);
        #1;
        ihit        = ih;
        stall       = st;
        redirect    = rd;
        redirect_pc = rpc;
        halt        = hl;
        imemload    = rd ? 32'hDEAD_BEEF : dw(addr_e);
        if (rd) exp_q.delete();
        n = addr_e + 32'd4;
        if (push_e) exp_q.push_back({dw(addr_e), n});
        #3;
        chk("imemREN", {31'd0, imemREN}, {31'd0, ren_e});
        chk("imemaddr", imemaddr, addr_e);
        if (valid_e != 2) chk("valid", {31'd0, valid}, valid_e[31:0]);
    endtask

    task automatic do_reset();
        @(posedge CLK);
        #2;
        RST = 1'b1;
        exp_q.delete();
        #1;
        chk("rst_ren", {31'd0, imemREN}, 32'd1);
        chk("rst_addr", imemaddr, 32'h0000_0200);
        chk("rst_valid", {31'd0, valid}, 32'd0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_npc", npc, 32'h0);
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_hold_addr", imemaddr, 32'h0000_0200);
        RST = 1'b0;
        ihit = 1'b0;
    endtask

    initial begin
        RST = 1'b1; ihit = 1'b0; stall = 1'b0; redirect = 1'b0;
        redirect_pc = 32'h0; halt = 1'b0; imemload = 32'h0;
        #2;
        chk("init_ren", {31'd0, imemREN}, 32'd1);
        chk("init_addr", imemaddr, 32'h0000_0200);
        chk("init_valid", {31'd0, valid}, 32'd0);
        chk("init_instr", instr, 32'h0);
        chk("init_npc", npc, 32'h0);
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;

        // streaming from PC_INIT
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h200, 1'b1, 0);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h204, 1'b1, 1);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h208, 1'b1, 1);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h20C, 1'b1, 1);
        step(1'b1, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 32'h210, 1'b0, 1);
        // stall fills the queue, then drains in order
        step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0,   1'b1, 0);
        step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h4,   1'b1, 1);
        step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h8,   1'b0, 1);
        step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h8,   1'b0, 1);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h8,   1'b0, 1);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h8,   1'b1, 1);
        step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'hC,   1'b1, 1);
        // redirect with full queue and a same-cycle ihit
        step(1'b1, 1'b1, 1'b1, 32'h1003, 1'b0, 1'b0, 32'h10, 1'b0, 1);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h1000, 1'b1, 0);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h1004, 1'b0, 1);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h1004, 1'b1, 0);
        // halt freezes fetch until a redirect
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h1008, 1'b0, 1);
        for (int i = 0; i < 3; i++)
            step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h1008, 1'b0, 0);
        step(1'b1, 1'b0, 1'b1, 32'h40, 1'b0, 1'b0, 32'h1008, 1'b0, 0);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h40, 1'b1, 0);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h44, 1'b0, 1);
        // PC wrap at the top of the address space
        step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h44, 1'b0, 0);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1, 0);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0, 1);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0, 0);
        // reset mid-miss with ihit still toggling
        @(posedge CLK);
        #1 ihit = 1'b1; imemload = 32'h1234_5678;
        do_reset();
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h200, 1'b0, 0);

`ifdef FETCH_PERF_CNT_EN
        do_reset();
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h200, 1'b0, 0);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h200, 1'b1, 0);
        for (int i = 1; i < 10; i++)
            step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h200 + 32'(i) * 32'd4, 1'b1, 1);
        @(posedge CLK);
        #1 ihit = 1'b0;
        #3;
        chk("fetch_count", fetch_count, 32'd10);
        chk("bubble_count", bubble_count, 32'd3);
        RST = 1'b1;
        exp_q.delete();
        #1;
        chk("fetch_count_rst", fetch_count, 32'd0);
        chk("bubble_count_rst", bubble_count, 32'd0);
        @(posedge CLK);
        #1 RST = 1'b0;
`endif

        repeat (2) @(posedge CLK);
        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
